// File: rtl/mic_pkg.sv
// Shared constants and width helpers for the microphone front-end blocks.
// The array top and each per-mic decimator derive their widths from here.
package mic_pkg;

    localparam int DEC_FACTOR_DEF = 64;
    localparam int ORDER_DEF      = 4;
    localparam int OUT_WIDTH_DEF  = 19;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Bit growth of an N-stage CIC with ratio R is N*log2(R); two extra bits
    // cover the signed +/-1 input and the +R^N full-scale corner.
    function automatic int acc_width(input int dec_factor, input int order);
        return order * clog2(dec_factor) + 2;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage with differential delay 1: out = in - in_delayed.
// The delay register only advances in the comb cycle that follows a tick.
module cic_comb_stage #(
    parameter int ACC_WIDTH = 26
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        en,
    input  logic                        clear,
    input  logic signed [ACC_WIDTH-1:0] comb_in,
    output logic signed [ACC_WIDTH-1:0] comb_out
);

    logic signed [ACC_WIDTH-1:0] dly_q;
    logic signed [ACC_WIDTH-1:0] dly_d;

    always_comb begin
        dly_d = dly_q;
        if (clear) begin
            dly_d = '0;
        end else if (en) begin
            dly_d = comb_in;
        end
    end

    // Wraps modulo 2^ACC_WIDTH, which the CIC relies on to undo integrator wrap.
    assign comb_out = comb_in - dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

endmodule

// File: rtl/pdm_cic_decimator.sv
// PDM-to-PCM CIC decimator: ORDER integrators at the PDM strobe rate, ORDER
// comb stages run once per DEC_FACTOR samples, truncated to OUT_WIDTH bits.
module pdm_cic_decimator
    import mic_pkg::*;
#(
    parameter int DEC_FACTOR = DEC_FACTOR_DEF,
    parameter int ORDER      = ORDER_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sample_en,
    input  logic                        pdm,
    input  logic                        clear,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        out_dv
);

    localparam int ACC_WIDTH = acc_width(DEC_FACTOR, ORDER);
    localparam int CNT_W     = clog2(DEC_FACTOR);
    localparam int WCNT_W    = clog2(ORDER + 1);
    localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;

    logic signed [ACC_WIDTH-1:0] integ_q [ORDER];
    logic signed [ACC_WIDTH-1:0] integ_d [ORDER];
    logic signed [ACC_WIDTH-1:0] x_s;
    logic        [CNT_W-1:0]     dcnt_q, dcnt_d;
    logic        [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                        comb_pend_q, comb_pend_d;
    logic signed [OUT_WIDTH-1:0] data_out_q, data_out_d;
    logic                        out_dv_q, out_dv_d;
    logic                        tick;
    logic                        comb_en;
    logic signed [ACC_WIDTH-1:0] comb_c [ORDER+1];

    // pdm=1 -> +1 (0...01), pdm=0 -> -1 (1...11)
    assign x_s     = {{(ACC_WIDTH-1){~pdm}}, 1'b1};
    assign tick    = sample_en && (dcnt_q == CNT_W'(DEC_FACTOR - 1));
    assign comb_en = comb_pend_q && !clear;

    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
        end
        if (clear) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_d[k] = '0;
            end
        end else if (sample_en) begin
            integ_d[0] = integ_q[0] + x_s;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_d[k-1];
            end
        end
    end

    always_comb begin
        dcnt_d      = dcnt_q;
        comb_pend_d = 1'b0;
        if (clear) begin
            dcnt_d = '0;
        end else if (sample_en) begin
            dcnt_d      = dcnt_q + 1'b1;
            comb_pend_d = tick;
        end
    end

    // Combs read the integrator value registered at the tick edge, so a new
    // sample arriving in the comb cycle does not disturb this block's result.
    assign comb_c[0] = integ_q[ORDER-1];

    for (genvar g = 0; g < ORDER; g++) begin : g_comb
        cic_comb_stage #(
            .ACC_WIDTH (ACC_WIDTH)
        ) u_comb (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (comb_en),
            .clear    (clear),
            .comb_in  (comb_c[g]),
            .comb_out (comb_c[g+1])
        );
    end

    always_comb begin
        wcnt_d     = wcnt_q;
        data_out_d = data_out_q;
        out_dv_d   = 1'b0;
        if (clear) begin
            wcnt_d = '0;
        end else if (comb_en) begin
            data_out_d = OUT_WIDTH'(comb_c[ORDER] >>> SHIFT);
            if (wcnt_q == WCNT_W'(ORDER)) begin
                out_dv_d = 1'b1;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            dcnt_q      <= '0;
            wcnt_q      <= '0;
            comb_pend_q <= 1'b0;
            data_out_q  <= '0;
            out_dv_q    <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
            dcnt_q      <= dcnt_d;
            wcnt_q      <= wcnt_d;
            comb_pend_q <= comb_pend_d;
            data_out_q  <= data_out_d;
            out_dv_q    <= out_dv_d;
        end
    end

    assign data_out = data_out_q;
    assign out_dv   = out_dv_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Bench for pdm_cic_decimator: the reference treats the CIC as a single FIR whose
// taps are the R-wide boxcar convolved with itself N times, decimated by R.
module tb_pdm_cic_decimator;

    localparam int R     = 64;
    localparam int N     = 4;
    localparam int OW    = 19;
    localparam int SHIFT = N * 6 + 2 - OW;
    localparam int HLEN  = N * (R - 1) + 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 sample_en = 1'b0;
    logic                 pdm = 1'b0;
    logic                 clear = 1'b0;
    logic signed [OW-1:0] data_out;
    logic                 out_dv;

    pdm_cic_decimator #(
        .DEC_FACTOR (R),
        .ORDER      (N),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sample_en (sample_en),
        .pdm       (pdm),
        .clear     (clear),
        .data_out  (data_out),
        .out_dv    (out_dv)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int h [HLEN];
    int xs [$];
    int nsamp;
    bit pend;
    bit pend_vld;
    int pend_val;
    int exp_data;
    bit exp_dv;
    int step_no;
    int restart_step;
    int last_dv_step;
    int want_spacing;
    bit chk_first;
    bit want_value_en;
    int want_value;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (step %0d)", tag, obs, expv, step_no);
        end
    endtask

    function automatic void build_h();
        int tmp [HLEN];
        int len;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (N) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < R; j++) tmp[i+j] += h[i];
            len += R - 1;
            h = tmp;
        end
    endfunction

    function automatic int model_y();
        int y;
        int n;
        y = 0;
        n = xs.size();
        for (int j = 0; j < HLEN && j < n; j++) y += h[j] * xs[n-1-j];
        return y;
    endfunction

    function automatic void model_restart();
        xs.delete();
        nsamp        = 0;
        pend         = 1'b0;
        last_dv_step = -1;
        restart_step = step_no;
    endfunction

    task automatic step(input bit en, input bit bitv, input bit clr);
        sample_en = en;
        pdm       = bitv;
        clear     = clr;
        @(posedge clk);
        step_no++;
        if (clr) begin
            exp_dv = 1'b0;
            model_restart();
        end else begin
            exp_dv = pend && pend_vld;
            if (pend) exp_data = pend_val;
            pend = 1'b0;
            if (en) begin
                xs.push_back(bitv ? 1 : -1);
                nsamp++;
                if (nsamp % R == 0) begin
                    pend     = 1'b1;
                    pend_val = model_y() >>> SHIFT;
                    pend_vld = (nsamp / R) > N;
                end
            end
        end
        #1;
        chk("out_dv", out_dv, exp_dv);
        chk("data_out", data_out, exp_data);
        if (out_dv === 1'b1) begin
            if (chk_first) begin
                chk("first_dv_latency", step_no - restart_step, 321);
                chk_first = 1'b0;
            end else if (want_spacing != 0 && last_dv_step >= 0) begin
                chk("dv_spacing", step_no - last_dv_step, want_spacing);
            end
            last_dv_step = step_no;
            if (want_value_en) chk("steady_value", data_out, want_value);
        end
    endtask

    task automatic async_reset();
        reset_n   = 1'b0;
        sample_en = 1'b0;
        clear     = 1'b0;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_out_dv", out_dv, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_dv", out_dv, 0);
        reset_n  = 1'b1;
        exp_data = 0;
        exp_dv   = 1'b0;
        step_no  = 0;
        model_restart();
    endtask

    task automatic set_mode(input bit first, input int spacing, input bit val_en, input int val);
        chk_first     = first;
        want_spacing  = spacing;
        want_value_en = val_en;
        want_value    = val;
    endtask

    initial begin
        build_h();
        step_no = 0;
        set_mode(0, 0, 0, 0);

        // Power-up reset
        repeat (3) @(posedge clk);
        #1;
        chk("por_data_out", data_out, 0);
        chk("por_out_dv", out_dv, 0);
        reset_n  = 1'b1;
        exp_data = 0;
        exp_dv   = 1'b0;
        model_restart();

        // Constant ones: positive full scale
        set_mode(1, 64, 1, 131072);
        for (int i = 0; i < 6 * R + 5; i++) step(1, 1, 0);

        // Constant zeros after clear: negative full scale
        step(0, 0, 1);
        set_mode(1, 64, 1, -131072);
        for (int i = 0; i < 6 * R + 5; i++) step(1, 0, 0);

        // Alternating 1,0 from reset: zero output
        @(negedge clk);
        async_reset();
        set_mode(1, 64, 1, 0);
        for (int i = 0; i < 6 * R + 5; i++) step(1, (i % 2) == 0, 0);

        // Strobe every third cycle, random bits
        step(0, 0, 1);
        set_mode(0, 3 * R, 0, 0);
        for (int i = 0; i < 8 * 3 * R + 10; i++) step((i % 3) == 0, 1'($urandom), 0);

        // Clear landing in the comb cycle of a post-warm-up tick
        step(0, 0, 1);
        set_mode(0, 64, 0, 0);
        for (int i = 0; i < 6 * R - 1; i++) step(1, 1'($urandom), 0);
        for (int i = 0; i < 2 * R && !pend; i++) step(1, 1'($urandom), 0);
        chk("tick_before_clear", pend, 1);
        step(1, 1'($urandom), 1);
        chk("clear_suppress_dv", out_dv, 0);
        set_mode(1, 64, 0, 0);
        for (int i = 0; i < 5 * R + 10; i++) step(1, 1'($urandom), 0);

        // Reset pulse mid-block, then behaves like power-up
        set_mode(0, 64, 0, 0);
        for (int i = 0; i < 100; i++) step(1, 1'($urandom), 0);
        async_reset();
        set_mode(1, 64, 1, 131072);
        for (int i = 0; i < 5 * R + 10; i++) step(1, 1, 0);

        sample_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
